// File: rtl/lms_tap_sched.sv
// Shared LMS coefficient updater: on start, walks every tap of an external bank
// once, computing w_new = sat(w - mu*e*x) and writing each result back in order.
module lms_tap_sched #(
  parameter int NTAPS     = 15,
  parameter int NB_I      = 18,
  parameter int NBF_I     = 15,
  parameter int NB_ERROR  = 19,
  parameter int NBF_ERROR = 15,
  parameter int NB        = 8,
  parameter int NBF       = 7,
  parameter int NB_MU     = 16,
  parameter int NB_IDX    = $clog2(NTAPS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_adapt_en,
  input  logic [NB_ERROR-1:0] i_error,
  input  logic [NB_MU-1:0]    i_mu,
  output logic [NB_IDX-1:0]   o_raddr,
  output logic                o_re,
  input  logic [NB-1:0]       i_w,
  input  logic [NB_I-1:0]     i_xk,
  output logic [NB_IDX-1:0]   o_waddr,
  output logic [NB-1:0]       o_wdata,
  output logic                o_we,
  output logic                o_busy,
  output logic                o_done
);

  localparam int NB_M1     = NB_ERROR + NB_MU;
  localparam int NB_FULL   = NB_M1 + NB_I;
  localparam int NB_DIFF   = NB_FULL + 1;
  localparam int FRAC_FULL = NBF_ERROR + NB_MU - 1 + NBF_I;
  localparam int SHIFT     = FRAC_FULL - NBF;
  localparam int NB_TRUNC  = NB_DIFF - SHIFT;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                     state_q;
  logic signed [NB_ERROR-1:0] err_q;
  logic signed [NB_MU-1:0]    mu_q;
  logic                       adapt_q;
  logic                       re_q;
  logic [NB_IDX-1:0]          raddr_q;
  logic                       rvalid_q;
  logic [NB_IDX-1:0]          ridx_q;
  logic                       wlast_q;
  logic                       we_q;
  logic [NB_IDX-1:0]          waddr_q;
  logic [NB-1:0]              wdata_q;
  logic                       busy_q;
  logic                       done_q;

  logic signed [NB_M1-1:0]    m1;
  logic signed [NB_FULL-1:0]  full;
  logic signed [NB_DIFF-1:0]  wAligned;
  logic signed [NB_DIFF-1:0]  fullExt;
  logic signed [NB_DIFF-1:0]  diff;
  logic [NB_TRUNC-1:0]        trunc;
  logic [NB_TRUNC-NB:0]       intBits;
  logic [NB-1:0]              wdata_d;
  logic                       unusedFracBits;

  // Full-precision update; dropping the low fraction bits of a two's-complement
  // value is a floor, and the result saturates if the kept integer part overflows.
  always_comb begin
    m1       = NB_M1'(err_q) * NB_M1'(mu_q);
    full     = NB_FULL'(m1) * NB_FULL'($signed(i_xk));
    wAligned = NB_DIFF'($signed(i_w)) <<< SHIFT;
    fullExt  = NB_DIFF'(full);
    diff     = wAligned - fullExt;
    trunc    = diff[NB_DIFF-1:SHIFT];
    intBits  = trunc[NB_TRUNC-1:NB-1];
    if ((&intBits) || (~|intBits)) begin
      wdata_d = trunc[NB-1:0];
    end else begin
      wdata_d = {trunc[NB_TRUNC-1], {(NB-1){~trunc[NB_TRUNC-1]}}};
    end
  end

  assign unusedFracBits = ^diff[SHIFT-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      err_q    <= '0;
      mu_q     <= '0;
      adapt_q  <= 1'b0;
      re_q     <= 1'b0;
      raddr_q  <= '0;
      rvalid_q <= 1'b0;
      ridx_q   <= '0;
      wlast_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Read-return stage follows the read strobe by one cycle, write stage by two.
      rvalid_q <= re_q;
      ridx_q   <= raddr_q;
      wlast_q  <= rvalid_q && (ridx_q == LAST_IDX);
      we_q     <= rvalid_q && adapt_q;
      waddr_q  <= ridx_q;
      if (rvalid_q) begin
        wdata_q <= wdata_d;
      end
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (i_start) begin
            err_q   <= $signed(i_error);
            mu_q    <= $signed(i_mu);
            adapt_q <= i_adapt_en;
            raddr_q <= '0;
            re_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          if (raddr_q == LAST_IDX) begin
            re_q    <= 1'b0;
            state_q <= DRAIN;
          end else begin
            raddr_q <= raddr_q + NB_IDX'(1);
          end
        end
        DRAIN: begin
          if (wlast_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_re    = re_q;
  assign o_raddr = raddr_q;
  assign o_we    = we_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_lms_tap_sched.sv
// Directed bench for lms_tap_sched: a registered-read bank model feeds the DUT,
// and every pass is checked cycle by cycle against the expected pass timeline.
module tb_lms_tap_sched;

  localparam int NTAPS    = 15;
  localparam int NB_I     = 18;
  localparam int NB_ERROR = 19;
  localparam int NB       = 8;
  localparam int NB_MU    = 16;
  localparam int NB_IDX   = 4;

  logic                clk = 1'b0;
  logic                i_rst;
  logic                i_start;
  logic                i_adapt_en;
  logic [NB_ERROR-1:0] i_error;
  logic [NB_MU-1:0]    i_mu;
  logic [NB_IDX-1:0]   o_raddr;
  logic                o_re;
  logic [NB-1:0]       i_w = '0;
  logic [NB_I-1:0]     i_xk = '0;
  logic [NB_IDX-1:0]   o_waddr;
  logic [NB-1:0]       o_wdata;
  logic                o_we;
  logic                o_busy;
  logic                o_done;

  logic [NB-1:0]   wMem [NTAPS];
  logic [NB_I-1:0] xMem [NTAPS];
  logic [NB-1:0]   expW [NTAPS];

  int compared   = 0;
  int mismatched = 0;

  lms_tap_sched dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_adapt_en (i_adapt_en),
    .i_error    (i_error),
    .i_mu       (i_mu),
    .o_raddr    (o_raddr),
    .o_re       (o_re),
    .i_w        (i_w),
    .i_xk       (i_xk),
    .o_waddr    (o_waddr),
    .o_wdata    (o_wdata),
    .o_we       (o_we),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  // Coefficient bank and delay line with one-cycle registered reads.
  always @(posedge clk) begin
    if (o_re) begin
      i_w  <= wMem[o_raddr];
      i_xk <= xMem[o_raddr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, ".re"},    32'(o_re),    32'd0);
    checkOutput({name, ".raddr"}, 32'(o_raddr), 32'd0);
    checkOutput({name, ".we"},    32'(o_we),    32'd0);
    checkOutput({name, ".waddr"}, 32'(o_waddr), 32'd0);
    checkOutput({name, ".wdata"}, 32'(o_wdata), 32'd0);
    checkOutput({name, ".busy"},  32'(o_busy),  32'd0);
    checkOutput({name, ".done"},  32'(o_done),  32'd0);
  endtask

  task automatic fillBank(input logic [NB-1:0] w, input logic [NB-1:0] expected);
    for (int k = 0; k < NTAPS; k++) begin
      wMem[k] = w;
      xMem[k] = 18'h08000;
      expW[k] = expected;
    end
  endtask

  // Called at the falling edge of cycle 0 to request a pass.
  task automatic applyStimulus(input logic adapt, input logic [NB_ERROR-1:0] e,
                               input logic [NB_MU-1:0] mu);
    i_start    = 1'b1;
    i_adapt_en = adapt;
    i_error    = e;
    i_mu       = mu;
  endtask

  // Walks cycles 1..NTAPS+4 of a pass; optionally raises a stray start mid-pass.
  task automatic runPass(input string name, input logic adapt, input int injectCycle,
                         input logic [NB_ERROR-1:0] altError);
    logic expRe, expWe;
    for (int c = 1; c <= NTAPS + 4; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      expRe = (c <= NTAPS);
      expWe = adapt && (c >= 3) && (c <= NTAPS + 2);
      checkOutput($sformatf("%s.re@%0d", name, c), 32'(o_re), 32'(expRe));
      if (expRe) begin
        checkOutput($sformatf("%s.raddr@%0d", name, c), 32'(o_raddr), 32'(c - 1));
      end
      checkOutput($sformatf("%s.we@%0d", name, c), 32'(o_we), 32'(expWe));
      if (expWe) begin
        checkOutput($sformatf("%s.waddr@%0d", name, c), 32'(o_waddr), 32'(c - 3));
        checkOutput($sformatf("%s.wdata@%0d", name, c), 32'(o_wdata), 32'(expW[c - 3]));
      end
      checkOutput($sformatf("%s.busy@%0d", name, c), 32'(o_busy), 32'(c <= NTAPS + 3));
      checkOutput($sformatf("%s.done@%0d", name, c), 32'(o_done), 32'(c == NTAPS + 3));
      if (c == injectCycle) begin
        i_start = 1'b1;
        i_error = altError;
      end
    end
  endtask

  initial begin
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_adapt_en = 1'b0;
    i_error    = '0;
    i_mu       = '0;
    fillBank(8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    i_rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic pass: 0.125 - 0.5*0.25*1.0");
    fillBank(8'h10, 8'h00);
    applyStimulus(1'b1, 19'h04000, 16'h2000);
    runPass("basic", 1'b1, 0, '0);

    $display("[TB] per-tap pass: w[k]=k/16, update 0.125");
    for (int k = 0; k < NTAPS; k++) begin
      wMem[k] = 8'(k * 8);
      xMem[k] = 18'h08000;
      expW[k] = 8'(k * 8 - 16);
    end
    applyStimulus(1'b1, 19'h04000, 16'h2000);
    runPass("pertap", 1'b1, 0, '0);

    $display("[TB] positive saturation");
    fillBank(8'h7F, 8'h7F);
    applyStimulus(1'b1, 19'h78000, 16'h4000);
    runPass("satpos", 1'b1, 0, '0);

    $display("[TB] negative saturation");
    fillBank(8'h80, 8'h80);
    applyStimulus(1'b1, 19'h08000, 16'h4000);
    runPass("satneg", 1'b1, 0, '0);

    $display("[TB] floor truncation of 2^-8");
    fillBank(8'h00, 8'hFF);
    applyStimulus(1'b1, 19'h00100, 16'h4000);
    runPass("trunc", 1'b1, 0, '0);

    $display("[TB] dry pass");
    fillBank(8'h10, 8'h00);
    applyStimulus(1'b0, 19'h04000, 16'h2000);
    runPass("dry", 1'b0, 0, '0);

    $display("[TB] start while busy, then back-to-back start");
    fillBank(8'h10, 8'h00);
    applyStimulus(1'b1, 19'h04000, 16'h2000);
    runPass("busy", 1'b1, 5, 19'h78000);
    fillBank(8'h00, 8'hFF);
    applyStimulus(1'b1, 19'h00100, 16'h4000);
    runPass("b2b", 1'b1, 0, '0);

    $display("[TB] reset mid-pass");
    fillBank(8'h10, 8'h00);
    applyStimulus(1'b1, 19'h04000, 16'h2000);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    i_rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("midreset");
    i_rst = 1'b0;
    for (int c = 8; c <= 12; c++) begin
      @(negedge clk);
      checkOutput($sformatf("postreset.we@%0d", c), 32'(o_we), 32'd0);
      checkOutput($sformatf("postreset.busy@%0d", c), 32'(o_busy), 32'd0);
    end
    fillBank(8'h7F, 8'h7F);
    applyStimulus(1'b1, 19'h78000, 16'h4000);
    runPass("fresh", 1'b1, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
